// File: rtl/mode_ctrl_if.sv
// Button-in / mode-out bundle between the front-panel driver and the mode controller.
// master drives the buttons; slave is the controller that owns the mode outputs.
interface mode_ctrl_if #(
  parameter int NUM_PAGES   = 4,
  parameter int NUM_FORMATS = 2
);
  localparam int PW = $clog2(NUM_PAGES);
  localparam int FW = $clog2(NUM_FORMATS);

  logic          in1;
  logic          in2;
  logic [PW-1:0] page;
  logic [FW-1:0] format;
  logic          mode_changed;

  modport master (output in1, in2, input page, format, mode_changed);
  modport slave  (input in1, in2, output page, format, mode_changed);
endinterface

// File: rtl/mode_ctrl_fsm.sv
// Display-mode controller: page axis with press/auto-repeat and idle return to page 0,
// format axis stepped by press only. All outputs registered.
module mode_ctrl_fsm #(
  parameter int NUM_PAGES      = 4,
  parameter int NUM_FORMATS    = 2,
  parameter int HOLD_CYCLES    = 50000000,
  parameter int REPEAT_CYCLES  = 12500000,
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mode_ctrl_if.slave  mc_if
);
  localparam int PW = $clog2(NUM_PAGES);
  localparam int FW = $clog2(NUM_FORMATS);
  localparam logic [PW-1:0]    PAGE_MAX = PW'(NUM_PAGES - 1);
  localparam logic [FW-1:0]    FMT_MAX  = FW'(NUM_FORMATS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} key_e;

  key_e             key_q, key_d;
  logic             in1_q, in2_q, arm_q;
  logic [CNT_W-1:0] hold_q, hold_d, idle_q, idle_d;
  logic [PW-1:0]    page_q, page_d;
  logic [FW-1:0]    fmt_q, fmt_d;
  logic             chg_q, chg_d;
  logic             press1, press2, step1, tmo;

  // The first edge after reset only samples the buttons, so a key held through reset
  // must be released and pressed again before it counts.
  assign press1 = arm_q & ~mc_if.in1 & in1_q;
  assign press2 = arm_q & ~mc_if.in2 & in2_q;

  always_comb begin
    key_d  = key_q;
    hold_d = hold_q;
    step1  = 1'b0;
    unique case (key_q)
      IDLE: begin
        if (press1) begin
          step1  = 1'b1;
          hold_d = '0;
          key_d  = HELD;
        end
      end
      HELD: begin
        if (mc_if.in1) begin
          key_d  = IDLE;
          hold_d = '0;
        end else if (HOLD_CYCLES != 0) begin
          if (hold_q == HOLD_LAST) begin
            step1  = 1'b1;
            hold_d = '0;
            key_d  = REPEAT;
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
      end
      REPEAT: begin
        if (mc_if.in1) begin
          key_d  = IDLE;
          hold_d = '0;
        end else if (hold_q == REP_LAST) begin
          step1  = 1'b1;
          hold_d = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        key_d  = IDLE;
        hold_d = '0;
      end
    endcase
  end

  always_comb begin
    // An in1 step in the timeout cycle wins over the return to page 0.
    tmo = (TIMEOUT_CYCLES != 0) && (idle_q == TMO_LAST) && (page_q != '0) && !step1;

    page_d = page_q;
    if (step1)    page_d = (page_q == PAGE_MAX) ? '0 : page_q + PW'(1);
    else if (tmo) page_d = '0;

    fmt_d = fmt_q;
    if (press2) fmt_d = (fmt_q == FMT_MAX) ? '0 : fmt_q + FW'(1);

    if (step1 || press2 || tmo || !mc_if.in1 || !mc_if.in2 || page_q == '0)
      idle_d = '0;
    else
      idle_d = idle_q + CNT_W'(1);

    chg_d = (page_d != page_q) || (fmt_d != fmt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= IDLE;
      in1_q  <= 1'b1;
      in2_q  <= 1'b1;
      arm_q  <= 1'b0;
      hold_q <= '0;
      idle_q <= '0;
      page_q <= '0;
      fmt_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      key_q  <= key_d;
      in1_q  <= mc_if.in1;
      in2_q  <= mc_if.in2;
      arm_q  <= 1'b1;
      hold_q <= hold_d;
      idle_q <= idle_d;
      page_q <= page_d;
      fmt_q  <= fmt_d;
      chg_q  <= chg_d;
    end
  end

  assign mc_if.page         = page_q;
  assign mc_if.format       = fmt_q;
  assign mc_if.mode_changed = chg_q;
endmodule

// File: tb/tb_mode_ctrl_fsm.sv
// Bench for mode_ctrl_fsm: directed scenarios with literal expectations plus a random
// phase, all continuously compared against a cycle-level behavioural model.
module tb_mode_ctrl_fsm;
  localparam int NP = 3, NF = 2, HOLD = 4, REP = 2, TMO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mode_ctrl_if #(.NUM_PAGES(NP), .NUM_FORMATS(NF)) bus ();

  mode_ctrl_fsm #(
    .NUM_PAGES(NP), .NUM_FORMATS(NF), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mc_if(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: n counts edges since the press step while in1 stays low; steps land at
  // n==HOLD and every REP after that.
  typedef struct {
    int page, fmt, idle, n;
    bit mc, prev1, prev2, armed, holding;
  } model_t;

  function automatic model_t next_model(model_t m, bit i1, bit i2);
    model_t r = m;
    bit p1, p2, s1, to;
    p1 = m.armed && !i1 && m.prev1;
    p2 = m.armed && !i2 && m.prev2;
    s1 = 1'b0;
    if (p1) begin
      s1 = 1'b1; r.holding = 1'b1; r.n = 0;
    end else if (m.holding && !i1) begin
      r.n = m.n + 1;
      if (HOLD != 0 && (r.n == HOLD || (r.n > HOLD && (r.n - HOLD) % REP == 0))) s1 = 1'b1;
    end else begin
      r.holding = 1'b0;
    end
    to = (TMO != 0) && (m.idle == TMO - 1) && (m.page != 0) && !s1;
    r.page = s1 ? (m.page + 1) % NP : (to ? 0 : m.page);
    r.fmt  = p2 ? (m.fmt + 1) % NF : m.fmt;
    r.idle = (s1 || p2 || to || !i1 || !i2 || m.page == 0) ? 0 : m.idle + 1;
    r.mc   = (r.page != m.page) || (r.fmt != m.fmt);
    r.prev1 = i1;
    r.prev2 = i2;
    r.armed = 1'b1;
    return r;
  endfunction

  model_t m;
  model_t m_rst;
  initial begin
    m_rst = '{page: 0, fmt: 0, idle: 0, n: 0, mc: 1'b0, prev1: 1'b1, prev2: 1'b1,
              armed: 1'b0, holding: 1'b0};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_rst;
    else        m <= next_model(m, bus.in1, bus.in2);
  end

  always @(posedge clk) begin
    #2;
    chk("model_page", int'(bus.page), m.page);
    chk("model_format", int'(bus.format), m.fmt);
    chk("model_changed", int'(bus.mode_changed), int'(m.mc));
  end

  int pulses;
  int done;
  int rep_exp [9];

  initial begin
    rep_exp = '{1, 1, 1, 1, 2, 2, 0, 0, 1};
    bus.in1 = 1'b1;
    bus.in2 = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_page", int'(bus.page), 0);
    chk("rst_format", int'(bus.format), 0);
    chk("rst_changed", int'(bus.mode_changed), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // page wrap 1,2,0
    for (int k = 1; k <= 3; k++) begin
      bus.in1 = 1'b0;
      @(negedge clk);
      chk("wrap_page", int'(bus.page), k % 3);
      chk("wrap_pulse", int'(bus.mode_changed), 1);
      bus.in1 = 1'b1;
      @(negedge clk);
      chk("wrap_pulse_end", int'(bus.mode_changed), 0);
    end
    chk("wrap_format", int'(bus.format), 0);

    // format axis, then a long hold
    for (int k = 1; k <= 2; k++) begin
      bus.in2 = 1'b0;
      @(negedge clk);
      chk("fmt_step", int'(bus.format), k % 2);
      bus.in2 = 1'b1;
      @(negedge clk);
    end
    bus.in2 = 1'b0;
    @(negedge clk);
    chk("fmt_hold_first", int'(bus.format), 1);
    pulses = 0;
    repeat (19) begin
      @(negedge clk);
      pulses += int'(bus.mode_changed);
    end
    chk("fmt_hold_pulses", pulses, 0);
    chk("fmt_hold_value", int'(bus.format), 1);
    bus.in2 = 1'b1;
    @(negedge clk);

    // auto-repeat from page 0
    bus.in1 = 1'b0;
    pulses  = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("rep_page", int'(bus.page), rep_exp[c]);
      pulses += int'(bus.mode_changed);
    end
    chk("rep_pulses", pulses, 4);
    bus.in1 = 1'b1;
    @(negedge clk);
    chk("rep_release_page", int'(bus.page), 1);
    chk("rep_release_pulse", int'(bus.mode_changed), 0);

    // timeout from page 2
    bus.in1 = 1'b0;
    @(negedge clk);
    chk("tmo_setup_page", int'(bus.page), 2);
    bus.in1 = 1'b1;
    pulses = 0;
    done   = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      pulses += int'(bus.mode_changed);
      if (bus.page == 0 && done == 0) done = c;
    end
    chk("tmo_latency", done, 10);
    chk("tmo_pulses", pulses, 1);
    chk("tmo_format", int'(bus.format), 1);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      pulses += int'(bus.mode_changed);
    end
    chk("tmo_page0_quiet", pulses, 0);

    // simultaneous press from (0,0)
    bus.in2 = 1'b0;
    @(negedge clk);
    bus.in2 = 1'b1;
    @(negedge clk);
    chk("sim_pre_format", int'(bus.format), 0);
    bus.in1 = 1'b0;
    bus.in2 = 1'b0;
    @(negedge clk);
    chk("sim_page", int'(bus.page), 1);
    chk("sim_format", int'(bus.format), 1);
    chk("sim_pulse", int'(bus.mode_changed), 1);
    bus.in1 = 1'b1;
    bus.in2 = 1'b1;
    @(negedge clk);
    chk("sim_single_pulse", int'(bus.mode_changed), 0);

    // reset while repeating, button still held afterwards
    bus.in1 = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_page", int'(bus.page), 0);
    chk("midrst_format", int'(bus.format), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(bus.mode_changed);
    end
    chk("midrst_held_page", int'(bus.page), 0);
    chk("midrst_held_pulses", pulses, 0);
    bus.in1 = 1'b1;
    @(negedge clk);
    bus.in1 = 1'b0;
    @(negedge clk);
    chk("midrst_repress_page", int'(bus.page), 1);
    bus.in1 = 1'b1;
    @(negedge clk);

    // random phase with periodic quiet windows to let the timeout fire
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 300 < 25) begin
        bus.in1 = 1'b1;
        bus.in2 = 1'b1;
        rst_n   = 1'b1;
      end else begin
        if ($urandom_range(0, 7) == 0) bus.in1 = ~bus.in1;
        if ($urandom_range(0, 5) == 0) bus.in2 = ~bus.in2;
        rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
